// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters,
// gating grants on the TDM slot that currently powers each request's target device.
module i2c_master_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDW       = 2,
    parameter logic [15:0] TIMEOUT   = 16'd60000,
    parameter logic [7:0]  START_WIN = 8'd16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [2*NUM_REQ-1:0]   req_dev,
    input  logic [7*NUM_REQ-1:0]   req_slave_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_data_wr,
    input  logic                   tdm_enable,
    input  logic [1:0]             active_device,
    input  logic                   slot_open,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             rd_data,
    output logic                   err,
    output logic                   m_enable,
    output logic                   m_rw,
    output logic [6:0]             m_slave_addr,
    output logic [7:0]             m_reg_addr,
    output logic [7:0]             m_data_wr,
    input  logic [7:0]             m_data_rd,
    input  logic                   m_busy,
    input  logic                   m_ack_error,
    output logic [IDW-1:0]         grant_id,
    output logic [2:0]             arb_state,
    output logic                   arb_busy
);

    // Requester handshake: req[i] is a level held until done[i] pulses for one
    // cycle; once granted the transaction runs to completion whatever req does.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           m_rw_q, m_rw_d;
    logic [6:0]     m_slave_addr_q, m_slave_addr_d;
    logic [7:0]     m_reg_addr_q, m_reg_addr_d;
    logic [7:0]     m_data_wr_q, m_data_wr_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           err_q, err_d;
    logic [15:0]    timer_q, timer_d;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;
    logic [IDW-1:0]     cand;
    logic               sel_rw;
    logic [6:0]         sel_slave_addr;
    logic [7:0]         sel_reg_addr;
    logic [7:0]         sel_data_wr;
    logic               launch_go;
    logic [15:0]        timer_inc;
    logic               start_expired;
    logic               run_expired;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] &&
                          (!tdm_enable || (slot_open && (req_dev[2*i +: 2] == active_device)));
        end
    end

    // Scan upward starting one past the last grant so every requester gets a turn.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(grant_id_q) + k) % NUM_REQ);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_rw         = 1'b0;
        sel_slave_addr = '0;
        sel_reg_addr   = '0;
        sel_data_wr    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_rw         = req_rw[i];
                sel_slave_addr = req_slave_addr[7*i +: 7];
                sel_reg_addr   = req_reg_addr[8*i +: 8];
                sel_data_wr    = req_data_wr[8*i +: 8];
            end
        end
    end

    assign launch_go     = pick_valid && !m_busy;
    assign timer_inc     = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    assign start_expired = (timer_q >= {8'd0, START_WIN});
    assign run_expired   = (timer_q >= TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (launch_go) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_START;
            S_START: begin
                if (m_busy) begin
                    state_d = S_RUN;
                end else if (start_expired) begin
                    state_d = S_DONE;
                end
            end
            S_RUN:    if (!m_busy || run_expired) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_enable = (state_q == S_LAUNCH);
        arb_busy = (state_q != S_IDLE);
        done     = '0;
        if (state_q == S_DONE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                done[i] = (grant_id_q == IDW'(i));
            end
        end
    end

    // Command fields only change on a grant, so they stay stable for the whole transaction.
    always_comb begin
        grant_id_d     = grant_id_q;
        m_rw_d         = m_rw_q;
        m_slave_addr_d = m_slave_addr_q;
        m_reg_addr_d   = m_reg_addr_q;
        m_data_wr_d    = m_data_wr_q;
        rd_data_d      = rd_data_q;
        err_d          = err_q;
        timer_d        = timer_q;
        case (state_q)
            S_IDLE: begin
                if (launch_go) begin
                    grant_id_d     = pick_idx;
                    m_rw_d         = sel_rw;
                    m_slave_addr_d = sel_slave_addr;
                    m_reg_addr_d   = sel_reg_addr;
                    m_data_wr_d    = sel_data_wr;
                end
            end
            S_LAUNCH: timer_d = '0;
            S_START: begin
                timer_d = timer_inc;
                if (!m_busy && start_expired) begin
                    err_d = 1'b1;
                end
            end
            S_RUN: begin
                timer_d = timer_inc;
                if (!m_busy) begin
                    rd_data_d = m_data_rd;
                    err_d     = m_ack_error;
                end else if (run_expired) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id_q     <= IDW'(NUM_REQ - 1);
            m_rw_q         <= 1'b0;
            m_slave_addr_q <= '0;
            m_reg_addr_q   <= '0;
            m_data_wr_q    <= '0;
            rd_data_q      <= '0;
            err_q          <= 1'b0;
            timer_q        <= '0;
        end else begin
            grant_id_q     <= grant_id_d;
            m_rw_q         <= m_rw_d;
            m_slave_addr_q <= m_slave_addr_d;
            m_reg_addr_q   <= m_reg_addr_d;
            m_data_wr_q    <= m_data_wr_d;
            rd_data_q      <= rd_data_d;
            err_q          <= err_d;
            timer_q        <= timer_d;
        end
    end

    assign grant_id     = grant_id_q;
    assign m_rw         = m_rw_q;
    assign m_slave_addr = m_slave_addr_q;
    assign m_reg_addr   = m_reg_addr_q;
    assign m_data_wr    = m_data_wr_q;
    assign rd_data      = rd_data_q;
    assign err          = err_q;
    assign arb_state    = state_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed and randomized bench for i2c_master_arbiter: a reference model picks the
// expected grant from the request mask and the i2c_master is emulated by bench tasks.
module tb_i2c_master_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int IDW       = 2;
    localparam int TB_TIMEOUT   = 300;
    localparam int TB_START_WIN = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [2*NUM_REQ-1:0] req_dev;
    logic [7*NUM_REQ-1:0] req_slave_addr;
    logic [8*NUM_REQ-1:0] req_reg_addr;
    logic [8*NUM_REQ-1:0] req_data_wr;
    logic                 tdm_enable;
    logic [1:0]           active_device;
    logic                 slot_open;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           rd_data;
    logic                 err;
    logic                 m_enable;
    logic                 m_rw;
    logic [6:0]           m_slave_addr;
    logic [7:0]           m_reg_addr;
    logic [7:0]           m_data_wr;
    logic [7:0]           m_data_rd;
    logic                 m_busy;
    logic                 m_ack_error;
    logic [IDW-1:0]       grant_id;
    logic [2:0]           arb_state;
    logic                 arb_busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference-model state: last granted index and last completed read byte.
    int         model_last;
    logic [7:0] last_rd;
    logic       f_rw [NUM_REQ];
    logic [6:0] f_sa [NUM_REQ];
    logic [7:0] f_ra [NUM_REQ];
    logic [7:0] f_wd [NUM_REQ];
    logic [IDW-1:0] exp_q[$];

    i2c_master_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDW       (IDW),
        .TIMEOUT   (16'(TB_TIMEOUT)),
        .START_WIN (8'(TB_START_WIN))
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_rw         (req_rw),
        .req_dev        (req_dev),
        .req_slave_addr (req_slave_addr),
        .req_reg_addr   (req_reg_addr),
        .req_data_wr    (req_data_wr),
        .tdm_enable     (tdm_enable),
        .active_device  (active_device),
        .slot_open      (slot_open),
        .done           (done),
        .rd_data        (rd_data),
        .err            (err),
        .m_enable       (m_enable),
        .m_rw           (m_rw),
        .m_slave_addr   (m_slave_addr),
        .m_reg_addr     (m_reg_addr),
        .m_data_wr      (m_data_wr),
        .m_data_rd      (m_data_rd),
        .m_busy         (m_busy),
        .m_ack_error    (m_ack_error),
        .grant_id       (grant_id),
        .arb_state      (arb_state),
        .arb_busy       (arb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_next(input logic [NUM_REQ-1:0] mask, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        req            = '0;
        req_rw         = '0;
        req_dev        = '0;
        req_slave_addr = '0;
        req_reg_addr   = '0;
        req_data_wr    = '0;
        tdm_enable     = 1'b0;
        active_device  = 2'd0;
        slot_open      = 1'b0;
        m_data_rd      = '0;
        m_busy         = 1'b0;
        m_ack_error    = 1'b0;
        repeat (3) step();
        rst_n      = 1'b1;
        step();
        model_last = NUM_REQ - 1;
        last_rd    = 8'h00;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [1:0] dev,
                           input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] wd);
        f_rw[i] = rw;
        f_sa[i] = sa;
        f_ra[i] = ra;
        f_wd[i] = wd;
        req_rw[i]              = rw;
        req_dev[2*i +: 2]      = dev;
        req_slave_addr[7*i +: 7] = sa;
        req_reg_addr[8*i +: 8] = ra;
        req_data_wr[8*i +: 8]  = wd;
        req[i]                 = 1'b1;
    endtask

    task automatic rand_req(input int i, input logic [1:0] dev);
        set_req(i, 1'($urandom_range(0, 1)), dev, 7'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_enable(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!m_enable && n < budget);
        chk("enable_seen", 32'(m_enable), 32'd1);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (done == '0 && n < budget);
        chk("done_seen", 32'(done != '0), 32'd1);
    endtask

    task automatic check_launch(input int e);
        chk("grant_id", 32'(grant_id), 32'(e));
        chk("m_rw", 32'(m_rw), 32'(f_rw[e]));
        chk("m_slave_addr", 32'(m_slave_addr), 32'(f_sa[e]));
        chk("m_reg_addr", 32'(m_reg_addr), 32'(f_ra[e]));
        chk("m_data_wr", 32'(m_data_wr), 32'(f_wd[e]));
        chk("launch_state", 32'(arb_state), 32'd1);
        chk("launch_busy", 32'(arb_busy), 32'd1);
    endtask

    // Called in the LAUNCH cycle: the emulated master is busy for busy_len cycles.
    task automatic serve(input int id, input int busy_len, input logic [7:0] rd,
                         input logic ack, input bit drop);
        int n;
        m_busy = 1'b1;
        step();
        chk("enable_one_cycle", 32'(m_enable), 32'd0);
        repeat (busy_len - 1) step();
        m_busy      = 1'b0;
        m_data_rd   = rd;
        m_ack_error = ack;
        wait_done(4, n);
        chk("done_latency", 32'(n >= 1 && n <= 2), 32'd1);
        chk("done_vec", 32'(done), 32'(1) << id);
        chk("rd_data", 32'(rd_data), 32'(rd));
        chk("err", 32'(err), 32'(ack));
        chk("done_grant_id", 32'(grant_id), 32'(id));
        last_rd = rd;
        if (drop) req = '0;
        step();
        chk("done_pulse_end", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int e;
        bit seen;
        logic [NUM_REQ-1:0] mask;
        logic [NUM_REQ-1:0] elig;
        logic [7:0] rd;
        logic       ack;

        do_reset();
        chk("rst_state", 32'(arb_state), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'(NUM_REQ - 1));
        chk("rst_enable", 32'(m_enable), 32'd0);
        chk("rst_cmd", {m_rw, m_slave_addr, m_reg_addr, m_data_wr}, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single write with TDM off.
        set_req(0, 1'b0, 2'd0, 7'h68, 8'h10, 8'hA5);
        wait_enable(4, n);
        chk("first_latency", 32'(n), 32'd1);
        e = rr_next(req, model_last);
        model_last = e;
        check_launch(e);
        serve(e, 20, 8'h00, 1'b0, 1'b1);

        // Read with NACK.
        set_req(2, 1'b1, 2'd0, 7'h50, 8'h22, 8'h00);
        e = rr_next(req, model_last);
        wait_enable(4, n);
        model_last = e;
        check_launch(e);
        serve(e, 12, 8'h3C, 1'b1, 1'b1);
        chk("idle_after_done", 32'(arb_state), 32'd0);

        // Round-robin among 0, 1, 3 held high.
        do_reset();
        rand_req(0, 2'd0);
        rand_req(1, 2'd0);
        rand_req(3, 2'd0);
        for (int i = 0; i < 4; i++) begin
            e = rr_next(req, model_last);
            exp_q.push_back(IDW'(e));
            model_last = e;
        end
        for (int i = 0; i < 4; i++) begin
            logic [IDW-1:0] exp_id;
            wait_enable(4, n);
            exp_id = exp_q.pop_front();
            chk("rr_order", 32'(grant_id), 32'(exp_id));
            check_launch(int'(exp_id));
            serve(int'(exp_id), $urandom_range(2, 10), 8'($urandom), 1'b0, (i == 3));
        end

        // TDM gating.
        do_reset();
        tdm_enable    = 1'b1;
        active_device = 2'd0;
        slot_open     = 1'b1;
        rand_req(1, 2'd1);
        seen = 1'b0;
        repeat (8) begin
            step();
            seen |= m_enable | arb_busy;
        end
        chk("tdm_wrong_slot", 32'(seen), 32'd0);
        active_device = 2'd1;
        slot_open     = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            step();
            seen |= m_enable | arb_busy;
        end
        chk("tdm_slot_closed", 32'(seen), 32'd0);
        slot_open = 1'b1;
        wait_enable(4, n);
        chk("tdm_latency", 32'(n), 32'd1);
        model_last = 1;
        check_launch(1);
        serve(1, 5, 8'($urandom), 1'b0, 1'b1);

        // Randomized transactions, optionally gated by a random TDM slot.
        for (int it = 0; it < 16; it++) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            tdm_enable    = 1'($urandom_range(0, 1));
            active_device = 2'($urandom);
            slot_open     = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) rand_req(i, 2'($urandom));
            end
            elig = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                elig[i] = mask[i] && (!tdm_enable || req_dev[2*i +: 2] == active_device);
            end
            if (elig == '0) begin
                seen = 1'b0;
                repeat (5) begin
                    step();
                    seen |= m_enable;
                end
                chk("rand_no_eligible", 32'(seen), 32'd0);
                tdm_enable = 1'b0;
                elig = mask;
            end
            e = rr_next(elig, model_last);
            wait_enable(4, n);
            model_last = e;
            check_launch(e);
            rd  = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            serve(e, $urandom_range(2, 30), rd, ack, 1'b1);
        end
        tdm_enable = 1'b0;

        // Master never asserts busy.
        rand_req(0, 2'd0);
        e = rr_next(req, model_last);
        wait_enable(4, n);
        model_last = e;
        wait_done(TB_START_WIN + 10, n);
        chk("start_win_lat", 32'(n >= TB_START_WIN && n <= TB_START_WIN + 3), 32'd1);
        chk("start_win_err", 32'(err), 32'd1);
        chk("start_win_rd", 32'(rd_data), 32'(last_rd));
        chk("start_win_done", 32'(done), 32'(1) << e);
        req = '0;
        step();

        // Master stuck busy: timeout, then no relaunch until busy falls.
        rand_req(2, 2'd0);
        e = rr_next(req, model_last);
        wait_enable(4, n);
        model_last = e;
        m_busy = 1'b1;
        wait_done(TB_TIMEOUT + 20, n);
        chk("timeout_lat", 32'(n >= TB_TIMEOUT && n <= TB_TIMEOUT + 4), 32'd1);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_rd", 32'(rd_data), 32'(last_rd));
        chk("timeout_done", 32'(done), 32'(1) << e);
        req = '0;
        rand_req(3, 2'd0);
        seen = 1'b0;
        repeat (20) begin
            step();
            seen |= m_enable;
        end
        chk("busy_blocks_grant", 32'(seen), 32'd0);
        m_busy = 1'b0;
        e = rr_next(req, model_last);
        wait_enable(4, n);
        model_last = e;
        check_launch(e);
        serve(e, 6, 8'h5A, 1'b0, 1'b1);

        // Reset in the middle of RUN.
        rand_req(1, 2'd0);
        wait_enable(4, n);
        m_busy = 1'b1;
        repeat (5) step();
        chk("mid_run_state", 32'(arb_state), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mrst_state", 32'(arb_state), 32'd0);
        chk("mrst_busy", 32'(arb_busy), 32'd0);
        chk("mrst_grant_id", 32'(grant_id), 32'(NUM_REQ - 1));
        chk("mrst_cmd", {m_rw, m_slave_addr, m_reg_addr, m_data_wr}, 32'd0);
        chk("mrst_rd_err", {23'd0, rd_data, err}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            step();
            seen |= (done != '0) | m_enable;
        end
        chk("mrst_no_done", 32'(seen), 32'd0);
        m_busy = 1'b0;
        req    = '0;
        rst_n  = 1'b1;
        step();
        chk("post_rst_idle", 32'(arb_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
